// File: rtl/svtime_pkg.sv
// Shared types and defaults for the svtime host-time scheduler.
package svtime_pkg;
  typedef enum logic [0:0] {IDLE = 1'b0, FETCH = 1'b1} sched_state_e;
  typedef logic [63:0] epoch_t;
  localparam int SCHED_MAX_AGE = 1000;
  localparam int SCHED_TIMEOUT = 64;
endpackage

// File: rtl/svtime_rr_arb.sv
// Combinational round-robin picker: first eligible requester at or after ptr.
module svtime_rr_arb #(
  parameter  int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] mask,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] win,
  output logic [IDX_W-1:0] win_idx,
  output logic             any_valid
);
  logic [N_REQ-1:0] elig;
  logic [IDX_W:0]   cand;

  assign elig = req & ~mask;

  always_comb begin
    win       = '0;
    win_idx   = '0;
    any_valid = 1'b0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(N_REQ)) cand = cand - (IDX_W+1)'(N_REQ);
      if (!any_valid && elig[cand[IDX_W-1:0]]) begin
        any_valid              = 1'b1;
        win_idx                = cand[IDX_W-1:0];
        win[cand[IDX_W-1:0]]   = 1'b1;
      end
    end
  end
endmodule

// File: rtl/svtime_query_sched.sv
// Shares one host-time source among N_REQ requesters through an aging cache,
// refetching only when the cached epoch is older than MAX_AGE cycles.
module svtime_query_sched
  import svtime_pkg::*;
#(
  parameter  int N_REQ   = 4,
  parameter  int MAX_AGE = SCHED_MAX_AGE,
  parameter  int TIMEOUT = SCHED_TIMEOUT,
  parameter  int EPOCH_W = 64,
  localparam int IDX_W   = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_i,
  output logic [N_REQ-1:0]   gnt_o,
  output logic               rsp_valid_o,
  output logic [IDX_W-1:0]   rsp_id_o,
  output logic [EPOCH_W-1:0] rsp_epoch_o,
  output logic [31:0]        rsp_age_o,
  output logic               rsp_stale_o,
  output logic               src_req_o,
  input  logic               src_ack_i,
  input  logic [EPOCH_W-1:0] src_epoch_i,
  output logic               cache_valid_o,
  output logic [31:0]        fetch_count_o,
  output logic               timeout_o
);
  localparam logic [31:0] AGE_MAX = 32'(MAX_AGE);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

  sched_state_e       state;
  logic [IDX_W-1:0]   ptr, win_idx, ptr_nxt;
  logic [N_REQ-1:0]   win;
  logic               any_valid, stale, need_fetch, degraded;
  logic [31:0]        age, tcnt;
  logic [EPOCH_W-1:0] cache;

  // Last cycle's grant masks its owner so a falling req_i is not served twice.
  svtime_rr_arb #(.N_REQ(N_REQ)) u_arb (
    .req       (req_i),
    .mask      (gnt_o),
    .ptr       (ptr),
    .win       (win),
    .win_idx   (win_idx),
    .any_valid (any_valid)
  );

  assign stale   = !cache_valid_o || (age >= AGE_MAX);
  // After a timeout, serve the degraded cache until it ages out again.
  assign need_fetch = degraded ? (age >= AGE_MAX) : stale;
  assign ptr_nxt = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= '0;
      age           <= '0;
      tcnt          <= '0;
      cache         <= '0;
      degraded      <= 1'b0;
      gnt_o         <= '0;
      rsp_valid_o   <= 1'b0;
      rsp_id_o      <= '0;
      rsp_epoch_o   <= '0;
      rsp_age_o     <= '0;
      rsp_stale_o   <= 1'b0;
      src_req_o     <= 1'b0;
      cache_valid_o <= 1'b0;
      fetch_count_o <= '0;
      timeout_o     <= 1'b0;
    end else begin
      gnt_o       <= '0;
      rsp_valid_o <= 1'b0;
      if (age < AGE_MAX) age <= age + 32'd1;
      case (state)
        IDLE: begin
          if (any_valid) begin
            if (need_fetch) begin
              state     <= FETCH;
              src_req_o <= 1'b1;
              tcnt      <= '0;
            end else begin
              gnt_o       <= win;
              rsp_valid_o <= 1'b1;
              rsp_id_o    <= win_idx;
              rsp_epoch_o <= cache_valid_o ? cache : '0;
              rsp_age_o   <= age;
              rsp_stale_o <= degraded;
              ptr         <= ptr_nxt;
            end
          end
        end
        FETCH: begin
          // An ack on the final timeout cycle still counts as success.
          if (src_ack_i) begin
            cache         <= src_epoch_i;
            cache_valid_o <= 1'b1;
            age           <= '0;
            degraded      <= 1'b0;
            fetch_count_o <= fetch_count_o + 32'd1;
            src_req_o     <= 1'b0;
            state         <= IDLE;
          end else if (tcnt == TO_LAST) begin
            src_req_o <= 1'b0;
            timeout_o <= 1'b1;
            degraded  <= 1'b1;
            age       <= '0;
            state     <= IDLE;
          end else begin
            tcnt <= tcnt + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
